vc_dir_flag_arbiter: RTL and testbench

Parametrised array of per-(virtual-channel, direction) sticky status flags with per-flag set/clear requests, a configurable conflict-resolution mode, and a round-robin drain port. It sits beside the router's VC/direction state: producers raise flags, and a single downstream consumer retires them one per accepted handshake. It also provides per-VC summaries and a population count.

---
 rtl/vc_dir_flag_pkg.sv | 25 ++
 rtl/vc_dir_rr_pick.sv | 30 +++
 rtl/vc_dir_flag_arbiter.sv | 95 +++++++++
 tb/tb_vc_dir_flag_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_dir_flag_pkg.sv
// rtl/vc_dir_flag_pkg.sv - shared constants and index helpers for the VC/direction flag arbiter
package vc_dir_flag_pkg;

  localparam int CONFLICT_HOLD = 0;
  localparam int CONFLICT_SET  = 1;
  localparam int CONFLICT_CLR  = 2;

  // A 1-entry dimension still needs a 1-bit field to carry its index.
  function automatic int width_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int idx_to_vc(input int idx, input int num_dir);
    return idx / num_dir;
  endfunction

  function automatic int idx_to_dir(input int idx, input int num_dir);
    return idx % num_dir;
  endfunction

  function automatic int vc_dir_to_idx(input int vc, input int dir, input int num_dir);
    return vc * num_dir + dir;
  endfunction

endpackage

// File: rtl/vc_dir_rr_pick.sv
// rtl/vc_dir_rr_pick.sv - combinational round-robin picker: first set request at or after ptr, wrapping
module vc_dir_rr_pick #(
  parameter int N  = 48,
  parameter int PW = 6
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] idx
);

  // First pass covers ptr..N-1, second pass the wrapped region 0..ptr-1.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (PW'(i) >= ptr)) begin
        found = 1'b1;
        idx   = PW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        idx   = PW'(i);
      end
    end
  end

endmodule

// File: rtl/vc_dir_flag_arbiter.sv
// rtl/vc_dir_flag_arbiter.sv - sticky per-(VC, direction) flags with conflict resolution and a round-robin drain port
module vc_dir_flag_arbiter
  import vc_dir_flag_pkg::*;
#(
  parameter int NUM_VC        = 4,
  parameter int NUM_DIR       = 12,
  parameter int CONFLICT_MODE = 0,
  localparam int N  = NUM_VC * NUM_DIR,
  localparam int PW = width_min1(N),
  localparam int CW = $clog2(N + 1),
  localparam int VW = width_min1(NUM_VC),
  localparam int DW = width_min1(NUM_DIR)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N-1:0]      set_i,
  input  logic [N-1:0]      clr_i,
  output logic [N-1:0]      flags_o,
  output logic [NUM_VC-1:0] vc_pending_o,
  output logic [CW-1:0]     count_o,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VW-1:0]     out_vc,
  output logic [DW-1:0]     out_dir
);

  logic [N-1:0]  flags, flags_nxt;
  logic [PW-1:0] ptr, lock_idx, pick_idx;
  logic          lock_v, pick_found, handshake;

  assign handshake = lock_v & out_ready;

  vc_dir_rr_pick #(.N(N), .PW(PW)) u_pick (
    .req   (flags),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    flags_nxt = flags;
    for (int i = 0; i < N; i++) begin
      case ({set_i[i], clr_i[i]})
        2'b10:   flags_nxt[i] = 1'b1;
        2'b01:   flags_nxt[i] = 1'b0;
        2'b11: begin
          if (CONFLICT_MODE == CONFLICT_SET)      flags_nxt[i] = 1'b1;
          else if (CONFLICT_MODE == CONFLICT_CLR) flags_nxt[i] = 1'b0;
          else                                    flags_nxt[i] = flags[i];
        end
        default: flags_nxt[i] = flags[i];
      endcase
      // The offered flag is owned by the consumer until it retires; a same-cycle set re-arms it.
      if (lock_v && (lock_idx == PW'(i)))
        flags_nxt[i] = handshake ? set_i[i] : 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      flags    <= '0;
      ptr      <= '0;
      lock_v   <= 1'b0;
      lock_idx <= '0;
    end else begin
      flags <= flags_nxt;
      if (handshake) begin
        lock_v <= 1'b0;
        ptr    <= (lock_idx == PW'(N - 1)) ? '0 : lock_idx + 1'b1;
      end else if (!lock_v && pick_found) begin
        lock_v   <= 1'b1;
        lock_idx <= pick_idx;
      end
    end
  end

  assign flags_o   = flags;
  assign out_valid = lock_v;
  assign out_vc    = VW'(idx_to_vc(int'(lock_idx), NUM_DIR));
  assign out_dir   = DW'(idx_to_dir(int'(lock_idx), NUM_DIR));

  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++)
      count_o = count_o + CW'(flags[i]);
  end

  always_comb begin
    vc_pending_o = '0;
    for (int v = 0; v < NUM_VC; v++)
      for (int d = 0; d < NUM_DIR; d++)
        vc_pending_o[v] = vc_pending_o[v] | flags[vc_dir_to_idx(v, d, NUM_DIR)];
  end

endmodule

// File: tb/tb_vc_dir_flag_arbiter.sv
// tb/tb_vc_dir_flag_arbiter.sv - scoreboard bench for vc_dir_flag_arbiter (4 VCs x 12 dirs)
module tb_vc_dir_flag_arbiter;

  localparam int NV = 4;
  localparam int ND = 12;
  localparam int N  = NV * ND;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  set_i, clr_i;
  logic          out_ready;

  logic [N-1:0]  f0, f1, f2;
  logic [NV-1:0] vp0, vp1, vp2;
  logic [5:0]    cnt0, cnt1, cnt2;
  logic          v0, v1, v2;
  logic [1:0]    vc0, vc1, vc2;
  logic [3:0]    dir0, dir1, dir2;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 clock = ~clock;

  vc_dir_flag_arbiter #(.NUM_VC(NV), .NUM_DIR(ND), .CONFLICT_MODE(0)) dut0 (
    .clock(clock), .reset(reset), .set_i(set_i), .clr_i(clr_i), .flags_o(f0),
    .vc_pending_o(vp0), .count_o(cnt0), .out_valid(v0), .out_ready(out_ready),
    .out_vc(vc0), .out_dir(dir0));

  vc_dir_flag_arbiter #(.NUM_VC(NV), .NUM_DIR(ND), .CONFLICT_MODE(1)) dut1 (
    .clock(clock), .reset(reset), .set_i(set_i), .clr_i(clr_i), .flags_o(f1),
    .vc_pending_o(vp1), .count_o(cnt1), .out_valid(v1), .out_ready(out_ready),
    .out_vc(vc1), .out_dir(dir1));

  vc_dir_flag_arbiter #(.NUM_VC(NV), .NUM_DIR(ND), .CONFLICT_MODE(2)) dut2 (
    .clock(clock), .reset(reset), .set_i(set_i), .clr_i(clr_i), .flags_o(f2),
    .vc_pending_o(vp2), .count_o(cnt2), .out_valid(v2), .out_ready(out_ready),
    .out_vc(vc2), .out_dir(dir2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_i = '0;
    clr_i = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    bit idle = 1'b0;
    for (int i = 0; i < limit && !idle; i++) begin
      @(negedge clock);
      if (cnt0 == 0 && !v0) idle = 1'b1;
    end
    chk("drain_done", 64'(idle), 64'd1);
    step();
  endtask

  // Monitor: every accepted offer must match the next expected retirement.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && v0 && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_retire: got vc %0d dir %0d expected none", vc0, dir0);
        end else begin
          int e;
          e = exp_q.pop_front();
          chk("retire_vc", 64'(vc0), 64'(e / ND));
          chk("retire_dir", 64'(dir0), 64'(e % ND));
        end
      end
    end
  end

  initial begin
    logic [N-1:0] ones;
    ones = '1;

    // Reset with all sets held: outputs stay clear, then all 48 appear and drain in order.
    reset = 1'b1;
    set_i = ones;
    clr_i = '0;
    out_ready = 1'b0;
    repeat (3) step();
    @(negedge clock);
    chk("rst_flags", 64'(f0), 64'd0);
    chk("rst_count", 64'(cnt0), 64'd0);
    chk("rst_pending", 64'(vp0), 64'd0);
    chk("rst_valid", 64'(v0), 64'd0);
    chk("rst_vc", 64'(vc0), 64'd0);
    chk("rst_dir", 64'(dir0), 64'd0);
    step();
    reset = 1'b0;
    step();
    set_i = '0;
    out_ready = 1'b1;
    @(negedge clock);
    chk("all_count", 64'(cnt0), 64'd48);
    chk("all_pending", 64'(vp0), 64'hf);
    for (int i = 0; i < N; i++) exp_q.push_back(i);
    wait_idle(200);

    // Single flag 13: offered two edges after the request, cleared on acceptance.
    set_i[13] = 1'b1;
    step();
    set_i = '0;
    @(negedge clock);
    chk("f13_set", 64'(f0[13]), 64'd1);
    chk("f13_count", 64'(cnt0), 64'd1);
    chk("f13_pending", 64'(vp0), 64'h2);
    chk("f13_not_yet_valid", 64'(v0), 64'd0);
    exp_q.push_back(13);
    step();
    @(negedge clock);
    chk("f13_valid", 64'(v0), 64'd1);
    chk("f13_vc", 64'(vc0), 64'd1);
    chk("f13_dir", 64'(dir0), 64'd1);
    step();
    @(negedge clock);
    chk("f13_cleared", 64'(cnt0), 64'd0);
    chk("f13_valid_drop", 64'(v0), 64'd0);

    // Order 0, 5, 47 from ptr 0, then the pointer wraps so 3 beats 40.
    step();
    do_reset();
    set_i[0] = 1'b1;
    set_i[5] = 1'b1;
    set_i[47] = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(5);
    exp_q.push_back(47);
    step();
    set_i = '0;
    wait_idle(40);
    set_i[3] = 1'b1;
    set_i[40] = 1'b1;
    exp_q.push_back(3);
    exp_q.push_back(40);
    step();
    set_i = '0;
    wait_idle(40);

    // Stall on flag 20 while a clear and a new set arrive.
    out_ready = 1'b0;
    set_i[20] = 1'b1;
    step();
    set_i = '0;
    step();
    @(negedge clock);
    chk("stall_valid", 64'(v0), 64'd1);
    chk("stall_vc", 64'(vc0), 64'd1);
    chk("stall_dir", 64'(dir0), 64'd8);
    for (int i = 0; i < 5; i++) begin
      step();
      clr_i = '0;
      set_i = '0;
      if (i == 1) begin
        clr_i[20] = 1'b1;
        set_i[2] = 1'b1;
      end
      @(negedge clock);
      chk("stall_hold_vc", 64'(vc0), 64'd1);
      chk("stall_hold_dir", 64'(dir0), 64'd8);
      chk("stall_flag20", 64'(f0[20]), 64'd1);
    end
    step();
    clr_i = '0;
    set_i = '0;
    @(negedge clock);
    chk("stall_flag2", 64'(f0[2]), 64'd1);
    exp_q.push_back(20);
    exp_q.push_back(2);
    step();
    out_ready = 1'b1;
    wait_idle(40);

    // Retire flag 10 with a same-cycle set: re-armed and re-offered; reset drops the lock.
    out_ready = 1'b0;
    set_i[10] = 1'b1;
    step();
    set_i = '0;
    step();
    exp_q.push_back(10);
    out_ready = 1'b1;
    set_i[10] = 1'b1;
    @(negedge clock);
    chk("race_valid", 64'(v0), 64'd1);
    chk("race_dir", 64'(dir0), 64'd10);
    step();
    set_i = '0;
    out_ready = 1'b0;
    @(negedge clock);
    chk("race_rearmed", 64'(f0[10]), 64'd1);
    chk("race_released", 64'(v0), 64'd0);
    step();
    @(negedge clock);
    chk("race_reoffer_valid", 64'(v0), 64'd1);
    chk("race_reoffer_dir", 64'(dir0), 64'd10);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("race_reset_valid", 64'(v0), 64'd0);
    chk("race_reset_flags", 64'(f0), 64'd0);

    // Conflict resolution across the three modes, flag 7 starting at 0 then at 1.
    step();
    set_i[7] = 1'b1;
    clr_i[7] = 1'b1;
    step();
    set_i = '0;
    clr_i = '0;
    @(negedge clock);
    chk("conf0_hold", 64'(f0[7]), 64'd0);
    chk("conf0_set", 64'(f1[7]), 64'd1);
    chk("conf0_clr", 64'(f2[7]), 64'd0);
    step();
    set_i[7] = 1'b1;
    step();
    clr_i[7] = 1'b1;
    step();
    set_i = '0;
    clr_i = '0;
    @(negedge clock);
    chk("conf1_hold", 64'(f0[7]), 64'd1);
    chk("conf1_set", 64'(f1[7]), 64'd1);
    chk("conf1_clr", 64'(f2[7]), 64'd0);
    step();
    do_reset();
    step();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
